// File: rtl/ysyx_24070016_ifu_fetch.sv
// Multi-cycle instruction fetch stage: owns the PC, fetches one instruction at a time over a
// valid/ready read channel and hands it to decode. Optional fault halt: YSYX_24070016_IFU_FAULT_EN.
module ysyx_24070016_ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] araddr,
    output logic            arvalid,
    input  logic            arready,
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      rresp,
    input  logic            rvalid,
    output logic            rready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    input  logic            wb_valid,
    input  logic [XLEN-1:0] wb_nextpc,
    output logic            fetch_fault
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // a raised valid (arvalid, inst_valid) holds with stable payload until that transfer.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AR    = 3'd1,
        S_R     = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4
`ifdef YSYX_24070016_IFU_FAULT_EN
        ,
        S_HALT  = 3'd5
`endif
    } state_t;

    state_t          state, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            pc_q   <= RESET_PC;
            inst_q <= '0;
        end else begin
            state  <= state_d;
            pc_q   <= pc_d;
            inst_q <= inst_d;
        end
    end

    always_comb begin
        state_d = state;
        pc_d    = pc_q;
        inst_d  = inst_q;
        case (state)
            S_IDLE: state_d = S_AR;
            S_AR: if (arready) state_d = S_R;
            S_R: if (rvalid) begin
`ifdef YSYX_24070016_IFU_FAULT_EN
                if (rresp != 2'b00) begin
                    state_d = S_HALT;
                end else begin
                    inst_d  = rdata;
                    state_d = S_ISSUE;
                end
`else
                inst_d  = rdata;
                state_d = S_ISSUE;
`endif
            end
            // Commit in the same cycle as the decode handshake skips the wait state.
            S_ISSUE: if (inst_ready) begin
                if (wb_valid) begin
                    pc_d    = wb_nextpc;
                    state_d = S_AR;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: if (wb_valid) begin
                pc_d    = wb_nextpc;
                state_d = S_AR;
            end
`ifdef YSYX_24070016_IFU_FAULT_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign araddr     = pc_q;
    assign arvalid    = (state == S_AR);
    assign rready     = (state == S_R);
    assign inst       = inst_q;
    assign inst_pc    = pc_q;
    assign inst_valid = (state == S_ISSUE);

`ifdef YSYX_24070016_IFU_FAULT_EN
    logic fault_q;

    // Sticky until reset; set by an error response on the read data channel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_q <= 1'b0;
        end else if (state == S_R && rvalid && rresp != 2'b00) begin
            fault_q <= 1'b1;
        end
    end

    assign fetch_fault = fault_q;
`else
    logic unused_rresp;
    assign unused_rresp = ^rresp;
    assign fetch_fault  = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_24070016_ifu_fetch.sv
// Bench for ysyx_24070016_ifu_fetch: directed scenarios plus random traffic, all outputs compared
// every cycle against a transaction-level model; works with or without YSYX_24070016_IFU_FAULT_EN.
module tb_ysyx_24070016_ifu_fetch;

`ifdef YSYX_24070016_IFU_FAULT_EN
    localparam bit FAULT_BUILD = 1'b1;
`else
    localparam bit FAULT_BUILD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        wb_valid;
    logic [31:0] wb_nextpc;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;

    ysyx_24070016_ifu_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .wb_valid   (wb_valid),
        .wb_nextpc  (wb_nextpc),
        .fetch_fault(fetch_fault)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents, a pure function of the address
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        case (a)
            32'h8000_0000: return 32'h0010_0093;
            32'h8000_0004: return 32'h0020_8133;
            default:       return a ^ {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: where the fetch life-cycle is (request, response, offer, commit)
    typedef enum int {PH_IDLE, PH_ADDR, PH_DATA, PH_OFFER, PH_COMMIT, PH_HALT} phase_t;
    phase_t      m_ph    = PH_IDLE;
    logic [31:0] m_pc    = 32'h8000_0000;
    logic [31:0] m_inst  = 32'h0;
    logic        m_fault = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph = PH_IDLE; m_pc = 32'h8000_0000; m_inst = 32'h0; m_fault = 1'b0;
        end else begin
            case (m_ph)
                PH_IDLE: m_ph = PH_ADDR;
                PH_ADDR: if (arready) m_ph = PH_DATA;
                PH_DATA: if (rvalid) begin
                    if (FAULT_BUILD && rresp != 2'b00) begin
                        m_fault = 1'b1;
                        m_ph    = PH_HALT;
                    end else begin
                        m_inst = mem_f(m_pc);
                        m_ph   = PH_OFFER;
                    end
                end
                PH_OFFER: if (inst_ready) begin
                    if (wb_valid) begin m_pc = wb_nextpc; m_ph = PH_ADDR; end
                    else m_ph = PH_COMMIT;
                end
                PH_COMMIT: if (wb_valid) begin m_pc = wb_nextpc; m_ph = PH_ADDR; end
                default: ;
            endcase
        end
    end

    // Scoreboard: every output against the model on every falling edge
    always @(negedge clk) begin
        check("arvalid", {31'b0, arvalid}, {31'b0, m_ph == PH_ADDR});
        check("rready", {31'b0, rready}, {31'b0, m_ph == PH_DATA});
        check("inst_valid", {31'b0, inst_valid}, {31'b0, m_ph == PH_OFFER});
        check("araddr", araddr, m_pc);
        check("inst_pc", inst_pc, m_pc);
        check("inst", inst, m_inst);
        check("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    end

    // Driver tasks
    task automatic set_in(input logic ar, input logic rv, input logic [1:0] rr,
                          input logic ir, input logic wv, input logic [31:0] npc);
        arready = ar; rvalid = rv; rresp = rr; inst_ready = ir; wb_valid = wv; wb_nextpc = npc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rdata = mem_f(araddr);
    endtask

    initial begin
        rst = 1'b0;
        rdata = 32'h0;
        set_in(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
        repeat (2) tick();
        check("rst_araddr", araddr, 32'h8000_0000);
        check("rst_inst", inst, 32'h0);
        check("rst_arvalid", {31'b0, arvalid}, 32'h0);

        // Release; address channel stalls for 3 cycles on the first fetch
        rst = 1'b1;
        set_in(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("stall_arvalid", {31'b0, arvalid}, 32'h1);
            check("stall_araddr", araddr, 32'h8000_0000);
            check("stall_rready", {31'b0, rready}, 32'h0);
            tick();
        end
        arready = 1'b1;
        tick();
        check("r_rready", {31'b0, rready}, 32'h1);
        tick();
        check("issue_inst", inst, 32'h0010_0093);
        check("issue_pc", inst_pc, 32'h8000_0000);
        check("issue_valid", {31'b0, inst_valid}, 32'h1);
        tick();
        check("wait_valid", {31'b0, inst_valid}, 32'h0);
        set_in(1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 32'h8000_0004);
        tick();
        check("next_araddr", araddr, 32'h8000_0004);
        check("next_arvalid", {31'b0, arvalid}, 32'h1);

        // Decode stalls 5 cycles; a commit pulse meanwhile must not move the PC
        set_in(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'b0, inst_valid}, 32'h1);
            check("hold_inst", inst, 32'h0020_8133);
            check("hold_pc", inst_pc, 32'h8000_0004);
            set_in(1'b1, 1'b1, 2'b00, 1'b0, i == 2, 32'hdead_beef);
            tick();
        end
        check("hold_pc_end", inst_pc, 32'h8000_0004);
        set_in(1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 32'h8000_0100);
        tick();
        check("short_arvalid", {31'b0, arvalid}, 32'h1);
        check("short_araddr", araddr, 32'h8000_0100);

        // Asynchronous reset while waiting for read data at 0x80000008
        set_in(1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 32'h8000_0008);
        tick();
        tick();
        tick();
        set_in(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
        tick();
        check("pre_rst_rready", {31'b0, rready}, 32'h1);
        check("pre_rst_araddr", araddr, 32'h8000_0008);
        #2 rst = 1'b0;
        #1;
        check("async_rready", {31'b0, rready}, 32'h0);
        check("async_arvalid", {31'b0, arvalid}, 32'h0);
        check("async_araddr", araddr, 32'h8000_0000);
        tick();
        rst = 1'b1;
        set_in(1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 32'h0);
        tick();
        check("restart_araddr", araddr, 32'h8000_0000);

        // Error response on the read data channel
        tick();
        tick();
`ifdef YSYX_24070016_IFU_FAULT_EN
        check("fault_set", {31'b0, fetch_fault}, 32'h1);
        set_in(1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 32'h8000_0040);
        for (int i = 0; i < 20; i++) begin
            check("halt_arvalid", {31'b0, arvalid}, 32'h0);
            check("halt_valid", {31'b0, inst_valid}, 32'h0);
            tick();
        end
        rst = 1'b0;
        #1;
        check("fault_clear", {31'b0, fetch_fault}, 32'h0);
        tick();
        rst = 1'b1;
`else
        check("noflt_inst", inst, 32'h0010_0093);
        check("noflt_valid", {31'b0, inst_valid}, 32'h1);
        check("noflt_fault", {31'b0, fetch_fault}, 32'h0);
`endif

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] npc;
            npc = ($urandom_range(0, 3) == 0) ? $urandom : (m_pc + 32'd4);
            set_in($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                   (!FAULT_BUILD && $urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                   $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, npc);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_24070016_ifu_fetch.md
Name: ysyx_24070016_ifu_fetch

Overview:
Multi-cycle instruction fetch stage that owns the PC. It issues read requests to instruction memory over a valid/ready address/response handshake. Each fetched instruction and its PC are presented to the decode stage over a valid/ready interface. After the decode/execute path commits, the stage loads the committed next PC and fetches again. It replaces the combinational pc-to-inst path in front of the IDU.

Parameters:
RESET_PC  32'h80000000  PC value loaded on reset
XLEN  32  address/data width; only 32 is supported

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
araddr  out  32  instruction read address
arvalid  out  1  read address valid
arready  in  1  memory accepts address
rdata  in  32  instruction read data
rresp  in  2  read response; 2'b00 = OKAY
rvalid  in  1  read data valid
rready  out  1  fetch stage accepts read data
inst  out  32  fetched instruction to IDU
inst_pc  out  32  PC of inst
inst_valid  out  1  inst/inst_pc valid
inst_ready  in  1  IDU accepts inst
wb_valid  in  1  commit strobe from write-back; wb_nextpc is valid
wb_nextpc  in  32  next PC after the committed instruction
fetch_fault  out  1  sticky fetch error; only active with IFU_FAULT_EN, otherwise tied 0

Behaviour:
- Registers:
  - pc_q: reset RESET_PC.
  - inst_q: reset 0.
  - state: reset S_IDLE.
- Outputs decode from state and registers only; no combinational path from inputs to outputs.
  - araddr = pc_q; arvalid = (state==S_AR).
  - rready = (state==S_R).
  - inst = inst_q; inst_pc = pc_q; inst_valid = (state==S_ISSUE).
- Values while rst=0: arvalid=0, rready=0, inst_valid=0, inst=0, inst_pc=RESET_PC, araddr=RESET_PC, fetch_fault=0.
- State transitions:
  - S_IDLE: unconditionally -> S_AR on the first clock after reset release.
  - S_AR: hold arvalid=1 with araddr stable until arready=1, then -> S_R. arvalid is never dropped before acceptance.
  - S_R: hold rready=1; on rvalid=1, capture rdata into inst_q, then -> S_ISSUE.
  - S_ISSUE: hold inst_valid=1 with inst/inst_pc stable until inst_ready=1.
    - inst_ready=1 and wb_valid=0: -> S_WAIT.
    - inst_ready=1 and wb_valid=1 in the same cycle: pc_q <= wb_nextpc, -> S_AR directly.
  - S_WAIT: on wb_valid=1, pc_q <= wb_nextpc, -> S_AR.
- wb_valid is ignored in S_IDLE, S_AR and S_R, and in S_ISSUE when inst_ready=0.
- Exactly one fetch is outstanding; no new request is issued before the previous instruction commits.
- Minimum latency, with arready and rvalid each asserted on first opportunity: S_AR (1) + S_R (1) + S_ISSUE (1). A 0-wait loop completes one instruction every 3 cycles; the wb_valid shortcut removes S_WAIT.
- wb_nextpc is loaded verbatim, with no alignment masking; araddr carries all 32 bits.
- Without IFU_FAULT_EN, rresp is ignored and rdata is forwarded regardless.
- Reset asserted mid-transaction (any state) immediately forces all reset values.
  - After release, the stage restarts at RESET_PC.
  - Memory responses still in flight are not tracked; rready=0 during reset.

Optional Feature:
Macro YSYX_24070016_IFU_FAULT_EN.
- Defined:
  - In S_R, rvalid=1 with rresp!=2'b00 sets fetch_fault=1 (sticky) and moves to state S_HALT; inst_q is not updated.
  - S_HALT holds arvalid=0, rready=0 and inst_valid=0 until reset.
  - fetch_fault is cleared only by reset.
- Not defined:
  - S_HALT does not exist, and fetch_fault is tied 0.
  - rresp is unused.

Test Plan:
- Reset release; arready=1, rvalid=1 one cycle after address acceptance with rdata=32'h00100093; inst_ready=1; wb_valid the cycle after handshake with wb_nextpc=32'h80000004 -> first araddr=32'h80000000; inst=32'h00100093 with inst_pc=32'h80000000 for 1 cycle; next arvalid with araddr=32'h80000004.
- arready held 0 for 3 cycles -> arvalid=1 and araddr=32'h80000000 stable all 3 cycles, rready=0 until acceptance, no inst_valid.
- inst_ready held 0 for 5 cycles in S_ISSUE with inst=32'h00208133 -> inst_valid, inst and inst_pc unchanged for all 5 cycles; a wb_valid pulse during these cycles does not change pc.
- inst_ready=1 and wb_valid=1 in the same cycle with wb_nextpc=32'h80000100 -> arvalid=1 the next cycle with araddr=32'h80000100; no S_WAIT cycle.
- rst driven 0 asynchronously while in S_R (pc=32'h80000008) -> rready, arvalid, inst_valid go 0 without waiting for a clock edge; after release, the first araddr is 32'h80000000.
- With YSYX_24070016_IFU_FAULT_EN: rresp=2'b10 with rvalid=1 -> fetch_fault=1 from the next cycle; inst_valid never asserts; arvalid stays 0 for 20 cycles; reset clears fetch_fault. Without the macro, the same stimulus -> inst=rdata forwarded, fetch_fault=0.
